// File: rtl/mult8_seq.sv
// -----------------------------------------------------------------------------
// adder8b: 8-bit ripple-carry adder. It is the only adder the multiplier uses.
//   A, B  : 8-bit addends
//   Cin   : carry in
//   S     : 8-bit sum
//   Cout  : carry out
//
// mult8_seq: 8x8 unsigned sequential shift-add multiplier. It takes 8 RUN
// cycles plus one DONE cycle per product.
//   clk   : clock; all state changes on the rising edge
//   rst   : synchronous, active-high reset
//   start : requests a multiply; only sampled while busy = 0
//   A     : multiplicand, captured on the accepting edge
//   B     : multiplier, captured on the accepting edge
//   P     : registered 16-bit product; holds its value until the next result
//   busy  : high from the accepting edge through the DONE cycle
//   done  : one-cycle pulse; P holds the new product while done is high
// -----------------------------------------------------------------------------
module adder8b (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  logic carry;

  // NOTE: every signal driven from always_comb gets a value before any branch
  // or loop. Otherwise the tool infers a latch to hold the old value.
  always_comb begin
    carry = Cin;
    S     = '0;
    for (int i = 0; i < 8; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end

endmodule

module mult8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  mcand;
  logic [7:0]  acc_hi;
  logic [7:0]  acc_lo;
  logic [3:0]  cnt;

  logic [7:0]  sum;
  logic        cout;
  logic [15:0] acc_nx;

  adder8b u_add (
    .A    (acc_hi),
    .B    (mcand),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // One shift-add step. When the multiplier bit is set, the adder carry
  // becomes the new MSB, so 0xFF * 0xFF loses nothing.
  always_comb begin
    acc_nx = {1'b0, acc_hi, acc_lo[7:1]};
    if (acc_lo[0]) begin
      acc_nx = {cout, sum, acc_lo[7:1]};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (cnt == 4'd7) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments only. Every register then
  // sees values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      P      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= A;
            acc_lo <= B;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= acc_nx;
          cnt              <= cnt + 4'd1;
          // P only changes on the final step. The intermediate accumulator
          // values never reach the output.
          if (cnt == 4'd7) P <= acc_nx;
        end
        default: ;
      endcase
    end
  end

  // busy and done are decoded from the state register only, so they cannot
  // glitch and do not depend combinationally on start.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult8_seq.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for mult8_seq. Inputs change and outputs are
// sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mult8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int vectors    = 0;
  int miscompares = 0;

  mult8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 8'hFF; B = 8'hFF;
    tick();
    tick();
    vectors++;
    if ({P, busy, done} !== {16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: P=%h busy=%b done=%b, want P=0000 busy=0 done=0", P, busy, done);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_basic();
    bit lat_ok = 1'b1;
    start = 1'b1; A = 8'h0F; B = 8'h0F;
    tick();                       // accepting edge k
    start = 1'b0; A = 8'h00; B = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || P !== 16'h0000) lat_ok = 1'b0;
      tick();
    end
    vectors++;
    if (!lat_ok) begin
      miscompares++;
      $display("FAIL basic_run_window: busy/done/P wrong during RUN, want busy=1 done=0 P=0000");
    end
    vectors++;
    if ({done, busy, P} !== {1'b1, 1'b1, 16'h00E1}) begin
      miscompares++;
      $display("FAIL basic_result: done=%b busy=%b P=%h, want 1 1 00E1", done, busy, P);
    end
    tick();
    vectors++;
    if ({done, busy, P} !== {1'b0, 1'b0, 16'h00E1}) begin
      miscompares++;
      $display("FAIL basic_done_width: done=%b busy=%b P=%h, want 0 0 00E1", done, busy, P);
    end
    tick(); tick();
    vectors++;
    if (P !== 16'h00E1) begin
      miscompares++;
      $display("FAIL basic_p_hold: P=%h, want 00E1", P);
    end
  endtask

  task automatic test_carry();
    start = 1'b1; A = 8'hFF; B = 8'hFF;
    tick();
    start = 1'b0;
    repeat (8) tick();
    vectors++;
    if ({done, P} !== {1'b1, 16'hFE01}) begin
      miscompares++;
      $display("FAIL carry_ffxff: done=%b P=%h, want 1 FE01", done, P);
    end
    tick();
    start = 1'b1; A = 8'h00; B = 8'hAB;
    tick();
    start = 1'b0;
    repeat (8) tick();
    vectors++;
    if ({done, P} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL carry_zero_operand: done=%b P=%h, want 1 0000", done, P);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; A = 8'h80; B = 8'h02;
    tick();                       // accepting edge k, start stays high
    A = 8'hFF; B = 8'hFF;         // operand changes during RUN must not matter
    repeat (7) tick();
    A = 8'h80; B = 8'h02;
    tick();                       // edge k+8
    vectors++;
    if ({done, P} !== {1'b1, 16'h0100}) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b P=%h, want 1 0100", done, P);
    end
    tick();                       // edge k+9: DONE -> IDLE, start ignored
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, want 0 0", busy, done);
    end
    tick();                       // edge k+10: re-accepted
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_reaccept: busy=%b, want 1", busy);
    end
    A = 8'h33; B = 8'h77;
    repeat (8) tick();
    vectors++;
    if ({done, P} !== {1'b1, 16'h0100}) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b P=%h, want 1 0100", done, P);
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    start = 1'b1; A = 8'h12; B = 8'h34;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({P, busy, done} !== {16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_state: P=%h busy=%b done=%b, want 0000 0 0", P, busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL abort_no_done: done pulse seen after abort, want none");
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    vectors++;
    if ({done, P} !== {1'b1, 16'h03A8}) begin
      miscompares++;
      $display("FAIL abort_rerun: done=%b P=%h, want 1 03A8", done, P);
    end
    tick();
  endtask

  // Each operation is issued in the IDLE cycle right after the previous DONE.
  task automatic test_vectors();
    logic [7:0]  va [11] = '{8'h01, 8'hFF, 8'h01, 8'h02, 8'hAA, 8'h10,
                             8'hFF, 8'h7F, 8'h80, 8'hC3, 8'h0D};
    logic [7:0]  vb [11] = '{8'h01, 8'h01, 8'hFF, 8'h80, 8'h55, 8'h10,
                             8'h02, 8'h7F, 8'h80, 8'h00, 8'h0B};
    logic [15:0] vp [11] = '{16'h0001, 16'h00FF, 16'h00FF, 16'h0100,
                             16'h3872, 16'h0100, 16'h01FE, 16'h3F01,
                             16'h4000, 16'h0000, 16'h008F};
    for (int i = 0; i < 11; i++) begin
      start = 1'b1; A = va[i]; B = vb[i];
      tick();
      start = 1'b0; A = ~va[i]; B = ~vb[i];
      repeat (8) tick();
      vectors++;
      if ({done, busy, P} !== {1'b1, 1'b1, vp[i]}) begin
        miscompares++;
        $display("FAIL vec_%0d %h*%h: done=%b busy=%b P=%h, want 1 1 %h",
                 i, va[i], vb[i], done, busy, P, vp[i]);
      end
      tick();
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL vec_%0d_return_idle: done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_abort();
    test_vectors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult8_seq.md
MULT8_SEQ -- requirements
Module: mult8_seq

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits to match adder8b.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiply; sampled only when busy=0.
REQ-005 A  input  8  multiplicand, unsigned.
REQ-006 B  input  8  multiplier, unsigned.
REQ-007 P  output  16  registered product, unsigned.
REQ-008 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-009 done  output  1  one-cycle pulse: P holds the new result.

Function
REQ-010 The block SHALL be a shift-add multiplier whose every 8-bit add is performed by one instance of adder8b (Cin tied 0); no behavioural "+" operator is used for the accumulation.
REQ-011 Internal registers SHALL be: state (IDLE, RUN, DONE), mcand[7:0], acc_hi[7:0], acc_lo[7:0] (initialised with B), cnt[3:0].
REQ-012 IDLE: start=1 at an edge SHALL load mcand=A, acc_lo=B, acc_hi=0, cnt=0, and set state=RUN; start=0 leaves state unchanged.
REQ-013 RUN, each edge: if acc_lo[0]=1, {acc_hi,acc_lo} <= {Cout, S, acc_lo[7:1]} with {Cout,S}=adder8b(acc_hi, mcand, 0); else {acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo[7:1]}; cnt <= cnt+1.
REQ-014 RUN SHALL last exactly 8 edges; on the edge where cnt=7, state <= DONE and P <= final {acc_hi,acc_lo}.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE on the next edge.
REQ-016 Latency: start accepted at edge k -> done=1 and P valid during the cycle after edge k+8; busy=1 from after edge k through the DONE cycle.
REQ-017 start while busy=1 (RUN or DONE) SHALL be ignored; A and B SHALL be ignored except at the accepting edge.
REQ-018 P SHALL hold its last value from the DONE cycle until the next DONE load or reset; intermediate accumulator values SHALL NOT appear on P.
REQ-019 The adder carry-out SHALL be retained into the shifted product MSB so that 0xFF*0xFF produces no overflow loss.
REQ-020 Earliest re-issue: start asserted in the cycle after DONE (state IDLE) SHALL be accepted; there is no dead cycle beyond DONE.
REQ-021 done and busy SHALL be decoded from registered state only (glitch-free, no combinational path from start).

Reset
REQ-022 rst=1 at an edge SHALL force state=IDLE, P=0x0000, busy=0, done=0, cnt=0, acc_hi=acc_lo=mcand=0, regardless of start.
REQ-023 rst asserted mid-RUN SHALL abort the operation: no done pulse, P=0x0000 after the edge.
REQ-024 rst and start high on the same edge: reset SHALL win; start is not accepted.

Verification
REQ-025 A=0x0F, B=0x0F, start 1 cycle -> busy for 9 cycles, done pulse 8 edges after acceptance, P=0x00E1.
REQ-026 A=0xFF, B=0xFF -> P=0xFE01 (carry-out path exercised every step); then A=0x00, B=0xAB -> P=0x0000.
REQ-027 A=0x80, B=0x02, start held high continuously -> first result P=0x0100 after 9 cycles, second operation accepted in the cycle after DONE with second result also 0x0100; A/B changes during RUN have no effect on P.
REQ-028 Start accepted with A=0x12, B=0x34, rst pulsed after 4 RUN edges -> no done, P=0x0000, busy=0; new start with same operands -> P=0x03A8.
REQ-029 Randomised 1000 operand pairs against a reference product model: P=A*B exactly, done width exactly 1 cycle, latency exactly 9 edges from acceptance to IDLE.
